// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM state encodings
// and a constant-evaluable ceil(log2) helper.
package debounce_pkg;

    localparam logic [1:0] ZERO  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] ONE   = 2'd2;
    localparam logic [1:0] WAIT0 = 2'd3;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: two-flop synchroniser, four-state qualification
// FSM counting shared prescaler ticks, and registered level/edge outputs.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    input  logic tick,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int unsigned           CNT_W    = clog2(STABLE + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE - 1);

    logic [1:0]       r_sync;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_rise;
    logic             r_fall;
    logic             w_s;

    assign w_s = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], sw};
        end
    end

    // The level reversion is tested before the tick, so a bounce coinciding
    // with the qualifying tick always cancels the transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ZERO;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ZERO: begin
                    if (w_s) begin
                        r_state <= WAIT1;
                        r_cnt   <= '0;
                    end
                end
                WAIT1: begin
                    if (!w_s) begin
                        r_state <= ZERO;
                    end else if (tick) begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ONE;
                            r_db    <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ONE: begin
                    if (!w_s) begin
                        r_state <= WAIT0;
                        r_cnt   <= '0;
                    end
                end
                WAIT0: begin
                    if (w_s) begin
                        r_state <= ONE;
                    end else if (tick) begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ZERO;
                            r_db    <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ZERO;
                    r_cnt   <= '0;
                    r_db    <= 1'b0;
                end
            endcase
        end
    end

    assign db   = r_db;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: one shared free-running prescaler feeding
// CH independent debounce_chan instances.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned CH     = 4,
    parameter int unsigned TICK_W = 19,
    parameter int unsigned STABLE = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          tick
);

    logic [TICK_W-1:0] r_presc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + TICK_W'(1);
        end
    end

    assign tick = &r_presc;

    for (genvar g = 0; g < CH; g++) begin : g_chan
        debounce_chan #(
            .STABLE(STABLE)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .sw  (sw[g]),
            .tick(tick),
            .db  (db[g]),
            .rise(rise[g]),
            .fall(fall[g])
        );
    end

endmodule
